matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Control sequencer for the team's 5x5 matrix-multiply datapath. It generates read addresses for the A and B operand memories, the multiply-accumulate enables, and the C result write strobes, so that C = A x B is computed one element at a time in row-major order. It sits between the top-level start/done handshake and the shared single MAC unit plus operand/result memories that feed the 25 x 64-bit result outputs.

## Interface
- N, 5, matrix dimension (square N x N); N >= 2
- AW, 5, memory address width; N*N <= 2**AW
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a multiply; sampled only in IDLE
- abort  input  1  synchronous cancel of the run in progress
- trans_b  input  1  B read transposed; latched at start; used only with MATSEQ_TRANSPOSE_EN
- busy  output  1  high while a run is in progress (RUN or DRAIN)
- done  output  1  one-cycle pulse after the last C write
- rd_en  output  1  operand read strobe to the A and B memories
- a_addr  output  AW  A read address, i*N+k
- b_addr  output  AW  B read address, k*N+j (normal) or j*N+k (transposed)
- mac_clr  output  1  with mac_en: load acc = product instead of accumulating
- mac_en  output  1  MAC consumes the operand pair read the previous cycle
- c_we  output  1  write the accumulator to C
- c_addr  output  AW  C write address, i*N+j

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 and abort=0 clears i, j, k to 0, latches trans_b, and moves to RUN.
- RUN: rd_en=1 every cycle. Loop order is k innermost, then j, then i. When k, j and i are all N-1, the next state is DRAIN.
- DRAIN: 2 cycles that flush the pipeline, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Pipeline stage 1:
  - mac_en = rd_en delayed by 1 cycle.
  - mac_clr = (k==0 and rd_en) delayed by 1 cycle.
- Pipeline stage 2:
  - c_we = (k==N-1 and rd_en) delayed by 2 cycles.
  - c_addr = i*N+j delayed by 2 cycles.
- Address arithmetic is unsigned and computed at AW width. Index counters are $clog2(N) bits wide.
- start outside IDLE is ignored, including during the DONE cycle.
- abort in RUN or DRAIN:
  - Next state is IDLE.
  - rd_en, mac_en, mac_clr and c_we are forced to 0 from the next edge. The pending pipeline is squashed.
  - No done pulse is issued.
- abort in IDLE or DONE has no effect. In IDLE, abort and start together leave the block in IDLE.
- rst forces IDLE in any state, including mid-run, and squashes the pipeline.

## Timing
- Reset values: busy=0, done=0, rd_en=0, mac_en=0, mac_clr=0, c_we=0, a_addr=0, b_addr=0, c_addr=0. The latched trans_b resets to 0.
- Cycle 0 is the edge that samples start. From there:
  - Cycles 1..N^3: rd_en=1.
  - Cycles 2..N^3+1: mac_en=1.
  - Element e is written at cycle N*e+N+2.
  - Cycles N^3+1 and N^3+2 are DRAIN.
  - done=1 at cycle N^3+3.
  - busy=1 for cycles 1..N^3+2.
- Run length start-to-done is N^3+3 cycles (128 for N=5). The earliest next start is sampled at cycle N^3+4.
- Address outputs hold their last value when rd_en=0 or c_we=0.

## Configuration
- MATSEQ_TRANSPOSE_EN defined: the latched trans_b selects b_addr = j*N+k when 1, and k*N+j when 0.
- MATSEQ_TRANSPOSE_EN undefined: the trans_b port still exists but is ignored. b_addr is always k*N+j and the latch is not built.

## Test plan
- Plain run, N=5, start at cycle 0:
  - cycle 1: a_addr=0, b_addr=0, mac_en=0.
  - cycle 2: a_addr=1, b_addr=5, mac_en=1, mac_clr=1.
  - cycle 7: c_we=1, c_addr=0.
  - cycle 127: c_we=1, c_addr=24.
  - cycle 128: done=1, busy=0.
- Functional check: A=identity and B=1..25 loaded via a MAC model. The C outputs o0..o24 must equal 1..25 after done.
- start held high throughout cycles 1..128: no restart and exactly one done. The new run begins only when start is sampled at cycle 129.
- abort at cycle 50: from cycle 51, busy=0 and rd_en=mac_en=c_we=0. No done pulse. The count of c_we pulses equals 9 (elements 0..8).
- rst asserted at cycle 60 of a run: all outputs reach their reset values at the next edge. A following start runs a full 128-cycle sequence correctly.
- With MATSEQ_TRANSPOSE_EN and trans_b=1 at start: cycle 2 gives b_addr=1 and cycle 6 gives b_addr=5. The same stimulus without the macro gives b_addr=5 at cycle 2.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// -----------------------------------------------------------------------------
// matmul_sequencer_if
// Bundles the start/done handshake and the operand/MAC/result strobes of the
// 5x5 matrix-multiply sequencer.
//   master : the controlling side (drives start/abort/trans_b, observes the rest)
//   slave  : the sequencer itself
// Signals:
//   start, abort, trans_b         control into the sequencer
//   busy, done                    run status
//   rd_en, a_addr, b_addr         operand memory reads
//   mac_en, mac_clr               MAC enables
//   c_we, c_addr                  result memory write
// -----------------------------------------------------------------------------
interface matmul_sequencer_if #(
   parameter int AW = 5
);
   logic          start;
   logic          abort;
   logic          trans_b;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] a_addr;
   logic [AW-1:0] b_addr;
   logic          mac_clr;
   logic          mac_en;
   logic          c_we;
   logic [AW-1:0] c_addr;

   modport master (
      output start, abort, trans_b,
      input  busy, done, rd_en, a_addr, b_addr, mac_clr, mac_en, c_we, c_addr
   );

   modport slave (
      input  start, abort, trans_b,
      output busy, done, rd_en, a_addr, b_addr, mac_clr, mac_en, c_we, c_addr
   );
endinterface

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
// Control sequencer for an N x N matrix multiply C = A x B on a single shared
// MAC. Elements of C are produced in row-major order; for each element the
// inner index k sweeps 0..N-1 issuing one operand read per cycle.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - matmul_sequencer_if.slave (start/abort/trans_b in; busy, done,
//          rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr out)
//
// Configuration macro:
//   MATSEQ_TRANSPOSE_EN - when defined, trans_b (latched at start) selects a
//                         transposed B read address j*N+k. When undefined,
//                         trans_b is ignored and no latch is built.
//
// All outputs are registered. Pipeline: operand read (rd_en) -> MAC one cycle
// later (mac_en/mac_clr) -> C write two cycles after the last read of an element.
// -----------------------------------------------------------------------------
module matmul_sequencer #(
   parameter int N  = 5,
   parameter int AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   matmul_sequencer_if.slave bus
);

   localparam int            CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
   localparam logic [CW-1:0] ZERO_IDX = {CW{1'b0}};
   localparam logic [AW-1:0] N_AW     = AW'(N);
   localparam logic [AW-1:0] ZERO_AW  = {AW{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_r, next_state_s;
   logic [CW-1:0] i_r, j_r, k_r;
   logic [CW-1:0] i_s, j_s, k_s;
   logic          drain_r, drain_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;
   logic          rd_en_r, rd_en_s;
   logic [AW-1:0] a_addr_r, a_addr_s;
   logic [AW-1:0] b_addr_r, b_addr_s;
   logic          mac_en_r, mac_en_s;
   logic          mac_clr_r, mac_clr_s;
   logic          we1_r, we1_s;
   logic [AW-1:0] caddr1_r, caddr1_s;
   logic          c_we_r, c_we_s;
   logic [AW-1:0] c_addr_r, c_addr_s;
   logic          last_s;
   logic          squash_s;
   logic          trans_sel_s;

`ifdef MATSEQ_TRANSPOSE_EN
   logic          trans_r, trans_nxt_s;
`endif

   // Row-major linear address row*N+col, evaluated at AW width.
   function automatic logic [AW-1:0] lin_addr(input logic [CW-1:0] row,
                                              input logic [CW-1:0] col);
      return AW'(row) * N_AW + AW'(col);
   endfunction

   assign last_s   = (i_r == LAST_IDX) && (j_r == LAST_IDX) && (k_r == LAST_IDX);
   // abort only cancels an active run; in IDLE/DONE it is a no-op
   assign squash_s = bus.abort && ((state_r == RUN) || (state_r == DRAIN));

`ifdef MATSEQ_TRANSPOSE_EN
   // The value used for the read being prepared: fresh trans_b on the start
   // transition, the latched copy afterwards.
   assign trans_sel_s = trans_nxt_s;
`else
   assign trans_sel_s = 1'b0;
`endif

   // Next-state, index counters and the strobes that follow the FSM.
   always_comb begin
      next_state_s = state_r;
      i_s          = i_r;
      j_s          = j_r;
      k_s          = k_r;
      drain_s      = drain_r;
      rd_en_s      = 1'b0;
      busy_s       = 1'b0;
      done_s       = 1'b0;
`ifdef MATSEQ_TRANSPOSE_EN
      trans_nxt_s  = trans_r;
`endif
      case (state_r)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               next_state_s = RUN;
               i_s          = ZERO_IDX;
               j_s          = ZERO_IDX;
               k_s          = ZERO_IDX;
               rd_en_s      = 1'b1;
               busy_s       = 1'b1;
`ifdef MATSEQ_TRANSPOSE_EN
               trans_nxt_s  = bus.trans_b;
`endif
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (bus.abort) begin
               next_state_s = IDLE;
            end else if (last_s) begin
               // counters stay at N-1 so the addresses hold through DRAIN
               next_state_s = DRAIN;
               drain_s      = 1'b0;
               busy_s       = 1'b1;
            end else begin
               rd_en_s = 1'b1;
               busy_s  = 1'b1;
               if (k_r == LAST_IDX) begin
                  k_s = ZERO_IDX;
                  if (j_r == LAST_IDX) begin
                     j_s = ZERO_IDX;
                     i_s = i_r + CW'(1);
                  end else begin
                     j_s = j_r + CW'(1);
                  end
               end else begin
                  k_s = k_r + CW'(1);
               end
            end
         end
         DRAIN: begin
            if (bus.abort) begin
               next_state_s = IDLE;
            end else if (drain_r) begin
               next_state_s = DONE;
               done_s       = 1'b1;
            end else begin
               drain_s = 1'b1;
               busy_s  = 1'b1;
            end
         end
         DONE: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Operand addresses for the next cycle; held whenever no read is issued.
   always_comb begin
      if (rd_en_s) begin
         a_addr_s = lin_addr(i_s, k_s);
         if (trans_sel_s) begin
            b_addr_s = lin_addr(j_s, k_s);
         end else begin
            b_addr_s = lin_addr(k_s, j_s);
         end
      end else begin
         a_addr_s = a_addr_r;
         b_addr_s = b_addr_r;
      end
   end

   // MAC and C-write pipeline; squash kills everything in flight.
   always_comb begin
      mac_en_s  = rd_en_r && !squash_s;
      mac_clr_s = rd_en_r && (k_r == ZERO_IDX) && !squash_s;
      we1_s     = rd_en_r && (k_r == LAST_IDX) && !squash_s;
      c_we_s    = we1_r && !squash_s;
      if (rd_en_r && (k_r == LAST_IDX)) begin
         caddr1_s = lin_addr(i_r, j_r);
      end else begin
         caddr1_s = caddr1_r;
      end
      if (we1_r && !squash_s) begin
         c_addr_s = caddr1_r;
      end else begin
         c_addr_s = c_addr_r;
      end
   end

   // FSM state and loop counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         i_r     <= ZERO_IDX;
         j_r     <= ZERO_IDX;
         k_r     <= ZERO_IDX;
         drain_r <= 1'b0;
`ifdef MATSEQ_TRANSPOSE_EN
         trans_r <= 1'b0;
`endif
      end else begin
         state_r <= next_state_s;
         i_r     <= i_s;
         j_r     <= j_s;
         k_r     <= k_s;
         drain_r <= drain_s;
`ifdef MATSEQ_TRANSPOSE_EN
         trans_r <= trans_nxt_s;
`endif
      end
   end

   // Registered outputs and pipeline stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         rd_en_r   <= 1'b0;
         a_addr_r  <= ZERO_AW;
         b_addr_r  <= ZERO_AW;
         mac_en_r  <= 1'b0;
         mac_clr_r <= 1'b0;
         we1_r     <= 1'b0;
         caddr1_r  <= ZERO_AW;
         c_we_r    <= 1'b0;
         c_addr_r  <= ZERO_AW;
      end else begin
         busy_r    <= busy_s;
         done_r    <= done_s;
         rd_en_r   <= rd_en_s;
         a_addr_r  <= a_addr_s;
         b_addr_r  <= b_addr_s;
         mac_en_r  <= mac_en_s;
         mac_clr_r <= mac_clr_s;
         we1_r     <= we1_s;
         caddr1_r  <= caddr1_s;
         c_we_r    <= c_we_s;
         c_addr_r  <= c_addr_s;
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.rd_en   = rd_en_r;
   assign bus.a_addr  = a_addr_r;
   assign bus.b_addr  = b_addr_r;
   assign bus.mac_en  = mac_en_r;
   assign bus.mac_clr = mac_clr_r;
   assign bus.c_we    = c_we_r;
   assign bus.c_addr  = c_addr_r;

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_sequencer
// Self-checking bench for matmul_sequencer. A cycle-indexed schedule model
// derived from the timing table predicts every output each cycle; a memory +
// MAC model consumes the strobes and the resulting C is compared with a plain
// triple-loop matrix product of randomly generated operands.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;

   localparam int N  = 5;
   localparam int AW = 5;
   localparam int NN = N * N;
   localparam int N3 = N * N * N;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   matmul_sequencer_if #(.AW(AW)) bus_if ();

   matmul_sequencer #(.N(N), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int     n_chk = 0;
   int     n_err = 0;
   longint amem [0:31];
   longint bmem [0:31];
   longint bmat [0:31];
   longint cmem [0:31];
   longint opa, opb, acc;
   int     last_a, last_b, last_c;

   // Single comparison point: counts and reports.
   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Operand memories and MAC fed by the sequencer strobes.
   always @(posedge clk) begin
      if (bus_if.rd_en === 1'b1) begin
         opa <= amem[bus_if.a_addr];
         opb <= bmem[bus_if.b_addr];
      end
      if (bus_if.mac_en === 1'b1) begin
         acc <= (bus_if.mac_clr === 1'b1) ? opa * opb : acc + opa * opb;
      end
      if (bus_if.c_we === 1'b1) begin
         cmem[bus_if.c_addr] <= acc;
      end
   end

   function automatic bit eff_t(input bit tr);
`ifdef MATSEQ_TRANSPOSE_EN
      return tr;
`else
      return 1'b0 & tr;
`endif
   endfunction

   function automatic int exp_writes(input int cut);
      int n = 0;
      for (int e = 0; e < NN; e++) begin
         if (N * e + N + 2 <= cut) n++;
      end
      return n;
   endfunction

   // rnd=0: A = identity, B = 1..25. rnd=1: random 8-bit entries.
   task automatic load_mats(input bit rnd, input bit tr);
      for (int x = 0; x < 32; x++) begin
         amem[x] = 0;
         bmem[x] = 0;
         bmat[x] = 0;
      end
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            amem[r*N+c] = rnd ? longint'($urandom_range(0, 255)) : ((r == c) ? 1 : 0);
            bmat[r*N+c] = rnd ? longint'($urandom_range(0, 255)) : longint'(r*N+c+1);
         end
      end
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (tr) bmem[c*N+r] = bmat[r*N+c];
            else    bmem[r*N+c] = bmat[r*N+c];
         end
      end
   endtask

   task automatic check_c();
      longint sum;
      for (int e = 0; e < NN; e++) begin
         sum = 0;
         for (int k = 0; k < N; k++) sum += amem[(e/N)*N+k] * bmat[k*N+(e%N)];
         check_val($sformatf("c[%0d]", e), cmem[e], sum);
      end
   endtask

   // One start with optional abort/rst at a given cycle. Entry: mid-cycle 0.
   task automatic run_seq(input bit hold, input int abort_at, input int rst_at,
                          input bit tr, output int we_cnt);
      int cut, last, idx, i, j, k;
      bit use_t, alive;
      bit e_rd, e_me, e_mc, e_we, e_busy, e_done;
      use_t = eff_t(tr);
      cut   = (abort_at >= 0) ? abort_at : rst_at;
      last  = (cut < 0) ? N3 + 4 : cut + 3;
      we_cnt = 0;
      bus_if.start   = 1'b1;
      bus_if.trans_b = tr;
      bus_if.abort   = 1'b0;
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         alive  = (cut < 0) || (c <= cut);
         e_rd = 0; e_me = 0; e_mc = 0; e_we = 0; e_busy = 0; e_done = 0;
         if (alive) begin
            e_rd = (c <= N3);
            if (e_rd) begin
               idx = c - 1;
               i = idx / NN;
               j = (idx / N) % N;
               k = idx % N;
               last_a = i*N + k;
               last_b = use_t ? (j*N + k) : (k*N + j);
            end
            e_me   = (c >= 2) && (c <= N3 + 1);
            e_mc   = e_me && ((c - 2) % N == 0);
            e_we   = (c >= N + 2) && ((c - N - 2) % N == 0) && ((c - N - 2) / N < NN);
            if (e_we) last_c = (c - N - 2) / N;
            e_busy = (c <= N3 + 2);
            e_done = (c == N3 + 3);
         end else if (rst_at >= 0) begin
            last_a = 0;
            last_b = 0;
            last_c = 0;
         end
         check_val($sformatf("rd_en@%0d", c),   bus_if.rd_en,   e_rd);
         check_val($sformatf("mac_en@%0d", c),  bus_if.mac_en,  e_me);
         check_val($sformatf("mac_clr@%0d", c), bus_if.mac_clr, e_mc);
         check_val($sformatf("c_we@%0d", c),    bus_if.c_we,    e_we);
         check_val($sformatf("busy@%0d", c),    bus_if.busy,    e_busy);
         check_val($sformatf("done@%0d", c),    bus_if.done,    e_done);
         check_val($sformatf("a_addr@%0d", c),  bus_if.a_addr,  last_a);
         check_val($sformatf("b_addr@%0d", c),  bus_if.b_addr,  last_b);
         check_val($sformatf("c_addr@%0d", c),  bus_if.c_addr,  last_c);
         if (bus_if.c_we === 1'b1) we_cnt++;
         bus_if.start = hold;
         bus_if.abort = (c == abort_at);
         rst          = (c == rst_at);
      end
   endtask

   initial begin
      int wc, cut;
      bit tr;
      rst            = 1'b1;
      bus_if.start   = 1'b0;
      bus_if.abort   = 1'b0;
      bus_if.trans_b = 1'b0;
      last_a = 0; last_b = 0; last_c = 0;
      repeat (3) @(negedge clk);
      check_val("rst_busy",    bus_if.busy,    1'b0);
      check_val("rst_done",    bus_if.done,    1'b0);
      check_val("rst_rd_en",   bus_if.rd_en,   1'b0);
      check_val("rst_mac_en",  bus_if.mac_en,  1'b0);
      check_val("rst_mac_clr", bus_if.mac_clr, 1'b0);
      check_val("rst_c_we",    bus_if.c_we,    1'b0);
      check_val("rst_a_addr",  bus_if.a_addr,  0);
      check_val("rst_b_addr",  bus_if.b_addr,  0);
      check_val("rst_c_addr",  bus_if.c_addr,  0);
      rst = 1'b0;

      // start together with abort in IDLE must not launch a run
      bus_if.start = 1'b1;
      bus_if.abort = 1'b1;
      @(negedge clk);
      check_val("idle_abort_busy",  bus_if.busy,  1'b0);
      check_val("idle_abort_rd_en", bus_if.rd_en, 1'b0);
      bus_if.start = 1'b0;
      bus_if.abort = 1'b0;
      @(negedge clk);
      check_val("idle_after_busy",  bus_if.busy,  1'b0);
      check_val("idle_after_rd_en", bus_if.rd_en, 1'b0);

      // identity x (1..25)
      load_mats(1'b0, 1'b0);
      run_seq(1'b0, -1, -1, 1'b0, wc);
      check_val("plain_writes", wc, NN);
      check_c();

      // start held high across the whole run, then a back-to-back run
      tr = 1'($urandom_range(0, 1));
      load_mats(1'b1, eff_t(tr));
      run_seq(1'b1, -1, -1, tr, wc);
      check_val("hold_writes", wc, NN);
      check_c();
      load_mats(1'b1, 1'b0);
      run_seq(1'b0, -1, -1, 1'b0, wc);
      check_val("b2b_writes", wc, NN);
      check_c();

      // abort at cycle 50, then at a random point in RUN/DRAIN
      run_seq(1'b0, 50, -1, 1'b0, wc);
      check_val("abort50_writes", wc, 9);
      cut = int'($urandom_range(2, N3 + 1));
      run_seq(1'b0, cut, -1, 1'b0, wc);
      check_val("abort_rnd_writes", wc, exp_writes(cut));

      // reset mid-run, then a full transposed-request run
      run_seq(1'b0, -1, 60, 1'b0, wc);
      check_val("rst60_writes", wc, exp_writes(60));
      load_mats(1'b1, eff_t(1'b1));
      run_seq(1'b0, -1, -1, 1'b1, wc);
      check_val("trans_writes", wc, NN);
      check_c();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
